// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder
//   Parses the PS/2 Set-2 byte stream (E0 extended and F0 break prefixes),
//   matches NUM_KEYS programmable scancodes, tracks which mapped keys are
//   held (typematic repeats are suppressed), and queues key events in a
//   show-ahead FIFO with a valid/ready handshake. A registered level
//   "current command" (lowest-index held key, all ones when idle) is also
//   provided.
//
// Ports
//   CLOCK_50      in   system clock
//   reset         in   asynchronous, active-high reset
//   rx_data       in   received byte from PS2_Controller
//   rx_data_en    in   one-cycle strobe, rx_data valid this cycle
//   clear         in   synchronous flush (FIFO, held keys, overflow, parser)
//   cmd_data      out  FIFO head: key index
//   cmd_is_break  out  FIFO head: 1 = release event
//   cmd_valid     out  FIFO non-empty
//   cmd_ready     in   consumer accepts the head when cmd_valid is 1
//   key_held      out  bit i = 1 while key i is held
//   current_cmd   out  lowest-index held key, else all ones
//   fifo_count    out  number of queued events
//   overflow      out  sticky, an event was dropped on a full FIFO
//
// Parser states
//   state      | meaning
//   IDLE       | no prefix seen; next plain byte is a make
//   EXT        | E0 seen; next plain byte is an extended make
//   BRK        | F0 seen; next plain byte is a break
//   EXT_BRK    | E0 and F0 seen; next plain byte is an extended break

module ps2_key_event_decoder #(
  parameter int                    NUM_KEYS     = 6,
  parameter int                    CMD_W        = 3,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES    = {8'h33, 8'h2A, 8'h1D, 8'h2D, 8'h35, 8'h34},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT      = '0,
  parameter int                    FIFO_DEPTH   = 4,
  parameter int                    REPORT_BREAK = 0
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_data_en,
  input  logic                          clear,
  output logic [CMD_W-1:0]              cmd_data,
  output logic                          cmd_is_break,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [NUM_KEYS-1:0]           key_held,
  output logic [CMD_W-1:0]              current_cmd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  logic [1:0]          state, state_nxt;
  logic                ev_make, ev_break, ev_ext;

  logic [NUM_KEYS-1:0] hit_mask;
  logic [CMD_W-1:0]    hit_idx;
  logic                hit;

  logic [NUM_KEYS-1:0] held_nxt;
  logic                push, push_brk;

  logic [CMD_W:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                full, pop, do_push, drop;
  logic [CMD_W:0]      head;

  logic [CMD_W-1:0]    cur_nxt;

  // Parser: prefixes only move the state; a plain byte yields one event.
  always_comb begin
    state_nxt = state;
    ev_make   = 1'b0;
    ev_break  = 1'b0;
    ev_ext    = 1'b0;
    if (rx_data_en) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == BYTE_E0)      state_nxt = ST_EXT;
          else if (rx_data == BYTE_F0) state_nxt = ST_BRK;
          else                         ev_make = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == BYTE_E0)      state_nxt = ST_EXT;
          else if (rx_data == BYTE_F0) state_nxt = ST_EXT_BRK;
          else begin
            ev_make   = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (rx_data == BYTE_F0)      state_nxt = ST_BRK;
          else if (rx_data == BYTE_E0) state_nxt = ST_EXT_BRK;
          else begin
            ev_break  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          if (rx_data == BYTE_E0 || rx_data == BYTE_F0) state_nxt = ST_EXT_BRK;
          else begin
            ev_break  = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      endcase
    end
  end

  // Key match; scanning downward lets the lowest matching index win.
  always_comb begin
    hit_mask = '0;
    hit_idx  = '0;
    hit      = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rx_data == KEY_CODES[8*i +: 8] && ev_ext == KEY_EXT[i]) begin
        hit_mask    = '0;
        hit_mask[i] = 1'b1;
        hit_idx     = CMD_W'(i);
        hit         = 1'b1;
      end
    end
  end

  // Held-key tracking and event generation.
  always_comb begin
    held_nxt = key_held;
    push     = 1'b0;
    push_brk = 1'b0;
    if (hit && ev_make && ((key_held & hit_mask) == '0)) begin
      held_nxt = key_held | hit_mask;
      push     = 1'b1;
    end
    if (hit && ev_break) begin
      held_nxt = key_held & ~hit_mask;
      if (REPORT_BREAK != 0 && ((key_held & hit_mask) != '0)) begin
        push     = 1'b1;
        push_brk = 1'b1;
      end
    end
  end

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = cmd_valid & cmd_ready;
  // A push into a full FIFO is still accepted when a pop frees the slot.
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      key_held <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= ST_IDLE;
      key_held <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      key_held <= held_nxt;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!clear && do_push) mem[wr_ptr] <= {push_brk, hit_idx};
  end

  // Lowest-index held key, all ones when nothing is held.
  always_comb begin
    cur_nxt = '1;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_held[i]) cur_nxt = CMD_W'(i);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) current_cmd <= '1;
    else       current_cmd <= cur_nxt;
  end

  assign cmd_valid    = (count != '0);
  assign head         = mem[rd_ptr];
  // Gate the head so the outputs read zero while the FIFO is empty.
  assign cmd_data     = cmd_valid ? head[CMD_W-1:0] : '0;
  assign cmd_is_break = cmd_valid ? head[CMD_W] : 1'b0;
  assign fifo_count   = count;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench for ps2_key_event_decoder. Configured with key 5
// extended (E0 33) and break reporting enabled.
module tb_ps2_key_event_decoder;

  localparam int NK = 6;
  localparam int CW = 3;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_data_en;
  logic          clear;
  logic [CW-1:0] cmd_data;
  logic          cmd_is_break;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [NK-1:0] key_held;
  logic [CW-1:0] current_cmd;
  logic [2:0]    fifo_count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  logic [CW:0] exp_q[$];
  logic [CW:0] mon_e;

  ps2_key_event_decoder #(
    .NUM_KEYS    (NK),
    .CMD_W       (CW),
    .KEY_CODES   ({8'h33, 8'h2A, 8'h1D, 8'h2D, 8'h35, 8'h34}),
    .KEY_EXT     (6'b100000),
    .FIFO_DEPTH  (4),
    .REPORT_BREAK(1)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_data_en  (rx_data_en),
    .clear       (clear),
    .cmd_data    (cmd_data),
    .cmd_is_break(cmd_is_break),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .key_held    (key_held),
    .current_cmd (current_cmd),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted head must match the oldest expected event.
  always @(negedge CLOCK_50) begin
    if (!reset && !clear && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event actual=%0h required=none", {cmd_is_break, cmd_data});
      end else begin
        mon_e = exp_q.pop_front();
        chk("event", 32'({cmd_is_break, cmd_data}), 32'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data    = b;
    rx_data_en = 1'b1;
    tick();
    rx_data_en = 1'b0;
  endtask

  task automatic expect_ev(input logic brk, input logic [CW-1:0] cmd);
    exp_q.push_back({brk, cmd});
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    cmd_ready = 1'b1;
    for (int n = 0; n < 20 && cmd_valid; n++) tick();
    chk({name, "_valid_low"}, 32'(cmd_valid), 0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    reset      = 1'b1;
    rx_data    = 8'h00;
    rx_data_en = 1'b0;
    clear      = 1'b0;
    cmd_ready  = 1'b0;
    tick();
    tick();
    chk("rst_key_held", 32'(key_held), 0);
    chk("rst_current_cmd", 32'(current_cmd), 7);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    tick();

    // Typematic repeat: one event only
    expect_ev(1'b0, 3'd0);
    send(8'h34);
    chk("t1_held_first", 32'(key_held), 6'b000001);
    send(8'h34);
    chk("t1_current_cmd", 32'(current_cmd), 0);
    send(8'h34);
    chk("t1_count", 32'(fifo_count), 1);
    chk("t1_held", 32'(key_held), 6'b000001);
    chk("t1_head", 32'({cmd_is_break, cmd_data}), 0);
    drain("t1");
    do_clear();

    // Make then break with break reporting
    cmd_ready = 1'b1;
    expect_ev(1'b0, 3'd1);
    send(8'h35);
    chk("t2_held_make", 32'(key_held), 6'b000010);
    tick();
    chk("t2_current_make", 32'(current_cmd), 1);
    send(8'hF0);
    expect_ev(1'b1, 3'd1);
    send(8'h35);
    chk("t2_held_break", 32'(key_held), 0);
    tick();
    chk("t2_current_idle", 32'(current_cmd), 7);
    drain("t2");
    do_clear();

    // Extended key 5
    cmd_ready = 1'b1;
    send(8'h33);
    chk("t3_plain_held", 32'(key_held), 0);
    chk("t3_plain_count", 32'(fifo_count), 0);
    send(8'hE0);
    expect_ev(1'b0, 3'd5);
    send(8'h33);
    chk("t3_ext_held", 32'(key_held), 6'b100000);
    send(8'hE0);
    send(8'hF0);
    expect_ev(1'b1, 3'd5);
    send(8'h33);
    chk("t3_ext_release", 32'(key_held), 0);
    drain("t3");
    do_clear();

    // Overflow: six presses into a depth-4 FIFO
    cmd_ready = 1'b0;
    expect_ev(1'b0, 3'd0); send(8'h34);
    expect_ev(1'b0, 3'd1); send(8'h35);
    expect_ev(1'b0, 3'd2); send(8'h2D);
    expect_ev(1'b0, 3'd3); send(8'h1D);
    send(8'h2A);
    send(8'hE0);
    send(8'h33);
    chk("t4_count", 32'(fifo_count), 4);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_held", 32'(key_held), 6'b111111);
    drain("t4");
    chk("t4_overflow_sticky", 32'(overflow), 1);
    do_clear();
    chk("t4_overflow_cleared", 32'(overflow), 0);

    // Full FIFO with simultaneous push and pop, then clear with a byte
    cmd_ready = 1'b0;
    expect_ev(1'b0, 3'd0); send(8'h34);
    expect_ev(1'b0, 3'd1); send(8'h35);
    expect_ev(1'b0, 3'd2); send(8'h2D);
    expect_ev(1'b0, 3'd3); send(8'h1D);
    chk("t5_full", 32'(fifo_count), 4);
    cmd_ready = 1'b1;
    expect_ev(1'b0, 3'd4);
    send(8'h2A);
    chk("t5_count_same", 32'(fifo_count), 4);
    chk("t5_no_overflow", 32'(overflow), 0);
    chk("t5_held", 32'(key_held), 6'b011111);
    clear      = 1'b1;
    rx_data    = 8'h34;
    rx_data_en = 1'b1;
    tick();
    clear      = 1'b0;
    rx_data_en = 1'b0;
    exp_q.delete();
    chk("t5_clear_count", 32'(fifo_count), 0);
    chk("t5_clear_held", 32'(key_held), 0);
    chk("t5_clear_valid", 32'(cmd_valid), 0);
    chk("t5_current_lag", 32'(current_cmd), 0);
    tick();
    chk("t5_current_idle", 32'(current_cmd), 7);

    // Reset after a break prefix
    cmd_ready = 1'b0;
    expect_ev(1'b0, 3'd0);
    send(8'h34);
    send(8'hF0);
    reset = 1'b1;
    exp_q.delete();
    #2;
    chk("t6_rst_held", 32'(key_held), 0);
    chk("t6_rst_valid", 32'(cmd_valid), 0);
    chk("t6_rst_count", 32'(fifo_count), 0);
    chk("t6_rst_current", 32'(current_cmd), 7);
    chk("t6_rst_head", 32'({cmd_is_break, cmd_data}), 0);
    chk("t6_rst_overflow", 32'(overflow), 0);
    tick();
    reset     = 1'b0;
    cmd_ready = 1'b1;
    tick();
    expect_ev(1'b0, 3'd2);
    send(8'h2D);
    chk("t6_make_held", 32'(key_held), 6'b000100);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
- Parametrised successor to the single-byte PS/2 key-to-code mapper.
- Parses the PS/2 Set-2 byte stream from PS2_Controller, including E0 extended and F0 break prefixes.
- Matches NUM_KEYS programmable keycodes and tracks which mapped keys are held, suppressing typematic repeats.
- Queues key events in a small FIFO with a valid/ready handshake for the audio control FSM, and also presents a level "current command" output.

Parameters:
- NUM_KEYS, 6: number of mapped keys; must satisfy 1 <= NUM_KEYS <= 2^CMD_W - 1.
- CMD_W, 3: command width. The command for key i is the value i.
- KEY_CODES, {8'h33,8'h2A,8'h1D,8'h2D,8'h35,8'h34}: flattened 8*NUM_KEYS scancode table. Key i is bits [8i+7:8i].
- KEY_EXT, 6'b0: bit i = 1 means key i requires the E0 prefix.
- FIFO_DEPTH, 4: event FIFO depth; power of two, >= 2.
- REPORT_BREAK, 0: 1 = key releases also push events.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte from PS2_Controller
- rx_data_en  in  1  one-cycle strobe; rx_data is valid this cycle
- clear  in  1  synchronous flush
- cmd_data  out  CMD_W  FIFO head: key index
- cmd_is_break  out  1  FIFO head: 1 = release event
- cmd_valid  out  1  FIFO non-empty
- cmd_ready  in  1  consumer accepts the head when cmd_valid is 1
- key_held  out  NUM_KEYS  bit i = 1 while key i is held
- current_cmd  out  CMD_W  lowest-index held key, else all ones (idle)
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of queued events
- overflow  out  1  sticky; set when an event was dropped

Behaviour:
- Reset values: key_held=0, current_cmd=all ones, cmd_valid=0, cmd_data=0, cmd_is_break=0, fifo_count=0, overflow=0, parser state IDLE, FIFO pointers 0.
- Parser FSM advances only on rx_data_en. States: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make(byte, ext=0), stay IDLE.
  - EXT: E0 -> EXT; F0 -> EXT_BRK; other byte -> make(byte, ext=1) -> IDLE.
  - BRK: F0 -> BRK; E0 -> EXT_BRK; other byte -> break(byte, ext=0) -> IDLE.
  - EXT_BRK: F0 or E0 -> EXT_BRK; other byte -> break(byte, ext=1) -> IDLE.
- Matching: key i matches when byte == KEY_CODES[i] and ext == KEY_EXT[i]. If several entries match, the lowest index wins. Unmatched bytes (AA, FA, FE, E1, unmapped keys) have no effect beyond the state transition.
- make on key i:
  - key_held[i] already 1 (typematic repeat): no event.
  - Otherwise set key_held[i] and push {break=0, cmd=i}.
- break on key i:
  - Clear key_held[i].
  - If REPORT_BREAK=1 and key_held[i] was 1, push {break=1, cmd=i}.
  - A break for a key not held never pushes.
- Latency:
  - rx_data_en at edge t -> key_held and FIFO updated at edge t+1.
  - cmd_valid rises at t+1 if the FIFO was empty.
  - current_cmd is registered from key_held and updates at t+2.
- FIFO: show-ahead. cmd_data and cmd_is_break reflect the head whenever cmd_valid=1. A pop occurs on cmd_valid & cmd_ready.
- Push while full without a pop in the same cycle: the new event is dropped, overflow is set, and FIFO contents are unchanged.
- Push and pop in the same cycle:
  - Count unchanged; this is legal when full.
  - When empty, the push is stored, no pop occurs, and count becomes 1.
- Pointers wrap modulo FIFO_DEPTH.
- overflow stays set until clear or reset.
- clear (synchronous) empties the FIFO and zeroes key_held, overflow and the parser state. current_cmd returns to all ones one cycle later. clear has priority over a simultaneous rx_data_en and cmd_ready, so that byte is discarded.
- reset asserted mid-sequence (for example after F0) leaves the parser in IDLE; the next byte is treated as a make.

Test Plan:
- Bytes 34, 34, 34 with cmd_ready=0 -> exactly one event (cmd_data=0, cmd_is_break=0); fifo_count=1; key_held=6'b000001; current_cmd=0 two cycles after the first strobe.
- Bytes 35 then F0 35 with REPORT_BREAK=1 -> events {0,1} then {1,1}; key_held returns to 0; current_cmd returns to 3'b111.
- KEY_EXT[5]=1, bytes 33 then E0 33 -> the first byte produces no event; the second pushes cmd=5. Then E0 F0 33 clears key_held[5].
- cmd_ready=0; press keys 0..5 in turn -> 4 events queued and overflow=1. Drain with cmd_ready=1 -> commands 0,1,2,3 in order, then cmd_valid=0.
- FIFO full with push and pop in the same cycle -> count stays 4, the new event is appended and overflow is not set. Next cycle, assert clear together with rx_data_en -> count=0, key_held=0, byte ignored.
- Assert reset after F0 -> all outputs at reset values. Byte 2D then gives cmd=2, break=0.
